ldpc_frame_io_ctrl: RTL
=======================

LDPC_FRAME_IO_CTRL -- requirements
Module: ldpc_frame_io_ctrl

Interface
REQ-001 SHALL have parameter L, default 32: circulant size, i.e. addresses per PE memory.
REQ-002 SHALL have parameter K, default 6: PE grid dimension, giving K*K PEs and K columns.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5: width of load/read addresses, equal to ceil(log2 L).
REQ-004 SHALL have parameter MESSAGE_WIDTH, default 5: intrinsic LLR width.
REQ-005 SHALL have parameter DISCARD_FRAMES, default 2: number of initial frames whose hard decisions are suppressed (decoder pipeline fill).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port in_valid / in_ready / in_llr, input / output / MESSAGE_WIDTH bits: intrinsic LLR input stream.
REQ-009 SHALL have port en, output, 1 bit: decoder enable.
REQ-010 SHALL have port ext_reset, output, 1 bit: one-cycle decoder frame-start pulse.
REQ-011 SHALL have ports pe_select / load_add / int_out, output, K*K / ADDR_WIDTH / MESSAGE_WIDTH bits: PE memory write strobe (one-hot), address and data.
REQ-012 SHALL have port f_id, input, 1 bit: decoder frame id; any toggle means a frame is complete.
REQ-013 SHALL have ports read_add / column_select, output, ADDR_WIDTH / K bits: hard-decision read address and one-hot column strobe.
REQ-014 SHALL have port dec_out_fin, input, K*K bits: hard decisions, bit x*K+y = PE row x, column y.
REQ-015 SHALL have ports out_valid / out_ready / out_data / out_addr / out_last, output / input / output / output / output, 1 / 1 / K*K / ADDR_WIDTH / 1 bits: decoded-word output stream.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the FSM state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, START, LOAD, WAIT, READ, CAPTURE, EMIT.
REQ-018 IDLE -> START when in_valid=1; START lasts exactly 1 cycle, drives ext_reset=1, samples f_id into prev_f_id, and then goes to LOAD.
REQ-019 LOAD: in_ready=1; on each in_valid&in_ready, sample n (0..L*K*K-1) is written with pe_select=one-hot(n/L), load_add=n%L, int_out=in_llr, all registered, so outputs appear the cycle after the handshake.
REQ-020 pe_select SHALL be all-zero in any cycle following no handshake; in_valid gaps stall the counter without loss.
REQ-021 After sample n=L*K*K-1 is accepted: LOAD -> WAIT, in_ready=0.
REQ-022 en=1 in LOAD, WAIT, READ, CAPTURE and EMIT; en=0 in IDLE and START.
REQ-023 WAIT: on f_id != prev_f_id, increment frame counter fcnt (saturates at DISCARD_FRAMES); go to READ if fcnt (pre-increment) >= DISCARD_FRAMES, else go to IDLE.
REQ-024 READ: row r from 0; for c=0..K-1 on consecutive cycles, drive read_add=r and column_select=one-hot(c); after c=K-1, go to CAPTURE.
REQ-025 CAPTURE: register dec_out_fin into out_data, set out_addr=r and out_last=(r==L-1), then go to EMIT.
REQ-026 EMIT: out_valid=1, with out_data/out_addr/out_last held stable until out_ready=1.
REQ-027 On an EMIT handshake: if r<L-1 then r++ and go to READ, else go to IDLE.
REQ-028 column_select SHALL be all-zero outside READ.
REQ-029 A new frame's load begins only from IDLE; no load/read overlap.
REQ-030 An f_id toggle outside WAIT SHALL be ignored.
REQ-031 The sample counter SHALL be ceil(log2(L*K*K+1)) bits wide; the column counter wraps at K; the row counter at L.

Reset
REQ-032 While reset=1, immediately: state=IDLE; all counters, fcnt and prev_f_id = 0; en, ext_reset, in_ready, out_valid, out_last, busy = 0; pe_select, column_select, load_add, read_add, int_out, out_data, out_addr = 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; the next frame restarts at sample 0, and fcnt restarts at 0 (discard applies again).

Verification
REQ-034 Reset: assert reset between clock edges -> all outputs 0 and busy=0 without a clock edge.
REQ-035 Load, defaults: stream 1152 samples with continuous in_valid -> exactly one ext_reset pulse; pe_select one-hot, stepping from bit 0 to bit 35 every 32 samples; load_add 0..31 repeating; in_ready drops after the 1152nd sample.
REQ-036 Discard: run 3 frames, toggling f_id after each load -> frames 1-2 produce no out_valid; frame 3 emits 32 words, out_addr 0..31, out_last only on addr 31.
REQ-037 Backpressure: hold out_ready=0 for 10 cycles on word 5 -> out_data/out_addr stable, no column_select activity; resumes on release.
REQ-038 Input gaps: deassert in_valid randomly 50% of cycles -> same PE write sequence as REQ-035, with pe_select zero in gap cycles.
REQ-039 Mid-load reset: reset at sample 600, then a full frame -> load restarts at pe_select bit 0, load_add 0; the frame is discarded (fcnt=0).

Source files
------------

// File: rtl/ldpc_frame_io_ctrl.sv
// Frame I/O sequencer for the LDPC decoder: scatters intrinsic LLRs into the PE
// memories, waits for the decoder to finish, then streams hard decisions out row by row.
//
// state   | meaning
// IDLE    | waiting for the first sample of a frame
// START   | one-cycle decoder frame-start pulse, f_id snapshot
// LOAD    | accepting L*K*K samples into the PE memories
// WAIT    | decoder running; waiting for an f_id toggle
// READ    | strobing the K columns of the current row
// CAPTURE | latching the row of hard decisions
// EMIT    | presenting the row until the sink accepts it
module ldpc_frame_io_ctrl #(
    parameter int L              = 32,
    parameter int K              = 6,
    parameter int ADDR_WIDTH     = 5,
    parameter int MESSAGE_WIDTH  = 5,
    parameter int DISCARD_FRAMES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MESSAGE_WIDTH-1:0] in_llr,
    output logic                     en,
    output logic                     ext_reset,
    output logic [K*K-1:0]           pe_select,
    output logic [ADDR_WIDTH-1:0]    load_add,
    output logic [MESSAGE_WIDTH-1:0] int_out,
    input  logic                     f_id,
    output logic [ADDR_WIDTH-1:0]    read_add,
    output logic [K-1:0]             column_select,
    input  logic [K*K-1:0]           dec_out_fin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [K*K-1:0]           out_data,
    output logic [ADDR_WIDTH-1:0]    out_addr,
    output logic                     out_last,
    output logic                     busy
);
    localparam int NPE  = K * K;
    localparam int NSMP = L * K * K;
    localparam int SW   = $clog2(NSMP + 1);
    localparam int PW   = (NPE > 1) ? $clog2(NPE) : 1;
    localparam int CW   = (K > 1) ? $clog2(K) : 1;
    localparam int FW   = (DISCARD_FRAMES > 0) ? $clog2(DISCARD_FRAMES + 1) : 1;

    typedef enum logic [2:0] {IDLE, START, LOAD, WAIT, READ, CAPTURE, EMIT} state_t;
    state_t state, state_nxt;

    logic [SW-1:0]         smp_cnt;
    logic [PW-1:0]         pe_cnt;
    logic [ADDR_WIDTH-1:0] la_cnt;
    logic [ADDR_WIDTH-1:0] row_cnt;
    logic [CW-1:0]         col_cnt;
    logic [FW-1:0]         fcnt;
    logic                  prev_f_id;

    logic load_hs, last_smp, fid_toggle, last_row, last_col, keep_frame;

    assign load_hs    = (state == LOAD) && in_valid;
    assign last_smp   = (smp_cnt == SW'(NSMP - 1));
    assign fid_toggle = (state == WAIT) && (f_id != prev_f_id);
    assign last_row   = (row_cnt == ADDR_WIDTH'(L - 1));
    assign last_col   = (col_cnt == CW'(K - 1));
    assign keep_frame = (fcnt >= FW'(DISCARD_FRAMES));
    assign read_add   = row_cnt;

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        en            = 1'b0;
        ext_reset     = 1'b0;
        out_valid     = 1'b0;
        busy          = (state != IDLE);
        column_select = '0;
        case (state)
            IDLE:    if (in_valid) state_nxt = START;
            START: begin
                ext_reset = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                en       = 1'b1;
                in_ready = 1'b1;
                if (load_hs && last_smp) state_nxt = WAIT;
            end
            WAIT: begin
                en = 1'b1;
                if (fid_toggle) state_nxt = keep_frame ? READ : IDLE;
            end
            READ: begin
                en = 1'b1;
                column_select[col_cnt] = 1'b1;
                if (last_col) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                en        = 1'b1;
                state_nxt = EMIT;
            end
            EMIT: begin
                en        = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = last_row ? IDLE : READ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            smp_cnt   <= '0;
            pe_cnt    <= '0;
            la_cnt    <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            fcnt      <= '0;
            prev_f_id <= 1'b0;
            pe_select <= '0;
            load_add  <= '0;
            int_out   <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pe_select <= '0;
            if (state == START) begin
                prev_f_id <= f_id;
                smp_cnt   <= '0;
                pe_cnt    <= '0;
                la_cnt    <= '0;
            end
            // PE index and address are walked as separate counters to avoid a divider
            if (load_hs) begin
                pe_select <= NPE'(1) << pe_cnt;
                load_add  <= la_cnt;
                int_out   <= in_llr;
                smp_cnt   <= smp_cnt + SW'(1);
                if (la_cnt == ADDR_WIDTH'(L - 1)) begin
                    la_cnt <= '0;
                    pe_cnt <= pe_cnt + PW'(1);
                end else begin
                    la_cnt <= la_cnt + ADDR_WIDTH'(1);
                end
            end
            if (fid_toggle) begin
                row_cnt <= '0;
                col_cnt <= '0;
                if (!keep_frame) fcnt <= fcnt + FW'(1);
            end
            if (state == READ) col_cnt <= last_col ? '0 : col_cnt + CW'(1);
            if (state == CAPTURE) begin
                out_data <= dec_out_fin;
                out_addr <= row_cnt;
                out_last <= last_row;
            end
            if (state == EMIT && out_ready) row_cnt <= last_row ? '0 : row_cnt + ADDR_WIDTH'(1);
        end
    end
endmodule
